// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction and data caches.
// Data requests win ties; a D-grant streak counter forces an I grant to keep fetch moving.
module mem_arbiter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate
);

    // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3; only ACCESS ends a transfer
    localparam logic [1:0] RAM_ACCESS  = 2'd2;
    localparam logic [2:0] DSTREAK_MAX = 3'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DSERV = 2'd1,
        ST_ISERV = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_dstreak;
    logic [2:0] w_dstreak_next;

    logic w_dreq;
    logic w_ram_ok;
    logic w_dcomplete;
    logic w_icomplete;

    assign w_dreq      = dREN | dWEN;
    assign w_ram_ok    = (ramstate == RAM_ACCESS);
    assign w_dcomplete = (r_state == ST_DSERV) && w_dreq && w_ram_ok;
    assign w_icomplete = (r_state == ST_ISERV) && iREN && w_ram_ok;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= ST_IDLE;
            r_dstreak <= '0;
        end else begin
            r_state   <= w_state_next;
            r_dstreak <= w_dstreak_next;
        end
    end

    // Every service returns to IDLE so a request still high on its completion cycle is not re-granted
    always_comb begin
        w_state_next   = r_state;
        w_dstreak_next = r_dstreak;
        case (r_state)
            ST_IDLE: begin
                if (iREN && (r_dstreak == DSTREAK_MAX)) begin
                    w_state_next = ST_ISERV;
                end else if (w_dreq) begin
                    w_state_next = ST_DSERV;
                end else if (iREN) begin
                    w_state_next = ST_ISERV;
                end
            end
            ST_DSERV: begin
                if (!w_dreq || w_ram_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISERV: begin
                if (!iREN || w_ram_ok) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_dcomplete) begin
            if (!iREN) begin
                w_dstreak_next = '0;
            end else if (r_dstreak >= DSTREAK_MAX) begin
                w_dstreak_next = DSTREAK_MAX;
            end else begin
                w_dstreak_next = r_dstreak + 3'd1;
            end
        end else if (w_icomplete) begin
            w_dstreak_next = '0;
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (r_state)
            ST_DSERV: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
            end
            ST_ISERV: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
            end
            default: begin
                ramREN = 1'b0;
            end
        endcase
    end

    assign iwait = ~w_icomplete;
    assign dwait = ~w_dcomplete;
    assign iload = ramload;
    assign dload = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios followed by randomized cache/RAM traffic,
// with a queue-based scoreboard checking every completion against a reference memory.
module tb_mem_arbiter;

    localparam int MAXD = 4;
    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        iREN = 1'b0;
    logic [31:0] iaddr = '0;
    logic        dREN = 1'b0;
    logic        dWEN = 1'b0;
    logic [31:0] daddr = '0;
    logic [31:0] dstore = '0;
    logic [31:0] ramload = '0;
    logic [1:0]  ramstate = FREE;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;

    mem_arbiter #(.MAX_DSTREAK(MAXD)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } dtxn_t;

    logic [31:0] iq[$];
    dtxn_t       dq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] ram_mem [logic [31:0]];

    int n_cmp = 0;
    int n_err = 0;
    int obs = 0;
    bit i_held = 1'b0;

    bit          i_pend = 1'b0, d_pend = 1'b0;
    bit          need_pi, need_pd;
    int          d_left, i_left, n_ord;
    logic [7:0]  ord;
    int          r;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [31:0] ram_read(input logic [31:0] a);
        return ram_mem.exists(a) ? ram_mem[a] : init_val(a);
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: pops the scoreboard on every completion and tracks the D streak seen by the caches
    always @(negedge CLK) begin : mon
        logic [31:0] exp_i;
        dtxn_t       e;
        if (nRST) begin
            check("ram_en_exclusive", 96'(ramREN & ramWEN), 96'(0));
            check("one_wait_low", 96'(iwait | dwait), 96'(1));
            if (!iwait) begin
                check("i_done_bus", 96'({ramstate, ramREN, ramWEN, ramaddr}),
                      96'({ACCESS, 1'b1, 1'b0, iaddr}));
                if (iq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL i_unexpected: iwait pulse at addr %h, required none", iaddr);
                end else begin
                    exp_i = iq.pop_front();
                    check("iload", 96'(iload), 96'(exp_i));
                    $display("I rd addr=%h data=%h", iaddr, iload);
                end
                obs = 0;
            end
            if (!dwait) begin
                check("d_done_bus", 96'({ramstate, ramaddr}), 96'({ACCESS, daddr}));
                if (dq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL d_unexpected: dwait pulse at addr %h, required none", daddr);
                end else begin
                    e = dq.pop_front();
                    check("d_addr", 96'(daddr), 96'(e.addr));
                    if (e.wr) begin
                        check("d_write", 96'({ramWEN, ramREN, ramstore}), 96'({1'b1, 1'b0, e.data}));
                        ref_mem[e.addr] = e.data;
                        $display("D wr addr=%h data=%h", daddr, ramstore);
                    end else begin
                        check("dload", 96'({ramREN, ramWEN, dload}), 96'({1'b1, 1'b0, e.data}));
                        $display("D rd addr=%h data=%h", daddr, dload);
                    end
                end
                check("dstreak_bound", 96'(!(iREN && i_held && obs == MAXD)), 96'(1));
                obs = iREN ? ((obs < MAXD) ? obs + 1 : MAXD) : 0;
                i_held = 1'b1;
            end else if (!iREN) begin
                i_held = 1'b0;
            end
        end else begin
            obs = 0;
            i_held = 1'b0;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, then idle
        repeat (2) @(negedge CLK);
        check("reset_outs", 96'({ramREN, ramWEN, iwait, dwait, ramaddr, ramstore}), 96'({4'b0011, 64'h0}));
        nRST = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            @(negedge CLK);
            check("idle_outs", 96'({ramREN, ramWEN, iwait, dwait, ramaddr, ramstore}), 96'({4'b0011, 64'h0}));
        end

        // Single I read: BUSY, BUSY, ACCESS
        step(); iREN = 1'b1; iaddr = 32'h40; iq.push_back(32'h8C220004); ramstate = FREE;
        @(negedge CLK); check("t2_c0", 96'({ramREN, iwait}), 96'(2'b01));
        for (int k = 1; k <= 2; k++) begin
            step(); ramstate = BUSY; ramload = 32'h0;
            @(negedge CLK); check("t2_busy", 96'({ramREN, ramWEN, iwait, ramaddr}), 96'({3'b101, 32'h40}));
        end
        step(); ramstate = ACCESS; ramload = 32'h8C220004;
        @(negedge CLK); check("t2_c3", 96'({iwait, iload}), 96'({1'b0, 32'h8C220004}));
        step(); iREN = 1'b0; ramstate = FREE; ramload = 32'h0;
        @(negedge CLK); check("t2_c4", 96'({ramREN, iwait}), 96'(2'b01));

        // Tie between I read and D write: D first, IDLE gap, then I
        step();
        iREN = 1'b1; iaddr = 32'h80; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD; ramstate = FREE;
        iq.push_back(ref_read(32'h80));
        dq.push_back('{1'b1, 32'h100, 32'hDEAD});
        @(negedge CLK); check("t3_idle", 96'({ramREN, ramWEN}), 96'(0));
        step(); ramstate = BUSY;
        @(negedge CLK);
        check("t3_d_busy", 96'({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait}),
              96'({2'b10, 32'h100, 32'hDEAD, 2'b11}));
        step(); ramstate = ACCESS;
        @(negedge CLK); check("t3_d_done", 96'({dwait, iwait, ramWEN}), 96'(3'b011));
        step(); dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK); check("t3_gap", 96'({ramREN, ramWEN, iwait, dwait}), 96'(4'b0011));
        step(); ramstate = ACCESS; ramload = ref_read(32'h80);
        @(negedge CLK); check("t3_i_done", 96'({ramREN, ramaddr, iwait}), 96'({1'b1, 32'h80, 1'b0}));
        step(); iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // Starvation guard: I held against 6 D reads, second I request behind the first
        d_left = 6; i_left = 2; ord = '0; n_ord = 0; need_pd = 1'b1; need_pi = 1'b1;
        for (int k = 0; k < 60 && (d_left > 0 || i_left > 0); k++) begin
            step();
            dREN = (d_left > 0);
            daddr = 32'h200 + 32'(4 * (6 - d_left));
            iREN = (i_left > 0);
            iaddr = 32'h84 + 32'(4 * (2 - i_left));
            if (need_pd && d_left > 0) begin dq.push_back('{1'b0, daddr, ref_read(daddr)}); need_pd = 1'b0; end
            if (need_pi && i_left > 0) begin iq.push_back(ref_read(iaddr)); need_pi = 1'b0; end
            #1;
            ramstate = (ramREN | ramWEN) ? ACCESS : FREE;
            ramload = ref_read(ramaddr);
            @(negedge CLK);
            if (!dwait) begin ord = {ord[6:0], 1'b1}; n_ord++; d_left--; need_pd = 1'b1; end
            if (!iwait) begin ord = {ord[6:0], 1'b0}; n_ord++; i_left--; need_pi = 1'b1; end
        end
        check("t4_order", 96'({4'(n_ord), ord}), 96'({4'd8, 8'b11110110}));
        step(); dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // D read retried through ERROR, then a withdrawn read
        step(); dREN = 1'b1; daddr = 32'h300; dq.push_back('{1'b0, 32'h300, ref_read(32'h300)}); ramstate = FREE;
        @(negedge CLK);
        for (int k = 0; k < 3; k++) begin
            step(); ramstate = ERROR; ramload = 32'hBAD0BAD0;
            @(negedge CLK); check("t5_err_hold", 96'({ramREN, ramaddr, dwait}), 96'({1'b1, 32'h300, 1'b1}));
        end
        step(); ramstate = ACCESS; ramload = ref_read(32'h300);
        @(negedge CLK); check("t5_done", 96'(dwait), 96'(0));
        step(); daddr = 32'h304; ramstate = FREE;
        @(negedge CLK); check("t5_idle", 96'({ramREN, dwait}), 96'(2'b01));
        step(); ramstate = BUSY;
        @(negedge CLK); check("t5_busy", 96'({ramREN, ramaddr, dwait}), 96'({1'b1, 32'h304, 1'b1}));
        step(); dREN = 1'b0; ramstate = BUSY;
        @(negedge CLK); check("t5_withdraw", 96'({ramREN, dwait}), 96'(2'b01));
        step(); dREN = 1'b1; daddr = 32'h308; dq.push_back('{1'b0, 32'h308, ref_read(32'h308)}); ramstate = FREE;
        @(negedge CLK); check("t5_back_idle", 96'({ramREN, dwait}), 96'(2'b01));
        step(); ramstate = ACCESS; ramload = ref_read(32'h308);
        @(negedge CLK); check("t5_regrant", 96'({ramREN, ramaddr, dwait}), 96'({1'b1, 32'h308, 1'b0}));
        step(); dREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // Asynchronous reset during a BUSY I service
        step(); iREN = 1'b1; iaddr = 32'h44; iq.push_back(ref_read(32'h44)); ramstate = FREE;
        @(negedge CLK);
        step(); ramstate = BUSY;
        @(negedge CLK); check("t6_iserv", 96'({ramREN, ramaddr, iwait}), 96'({1'b1, 32'h44, 1'b1}));
        #2; nRST = 1'b0; #1;
        check("t6_async_rst", 96'({ramREN, ramWEN, iwait, dwait, ramaddr}), 96'({4'b0011, 32'h0}));
        iq.delete();
        @(negedge CLK); ramstate = FREE; nRST = 1'b1; #1;
        check("t6_release_idle", 96'({ramREN, iwait}), 96'(2'b01));
        iq.push_back(ref_read(32'h44));
        step(); ramstate = ACCESS; ramload = ref_read(32'h44);
        @(negedge CLK); check("t6_regrant", 96'({ramREN, ramaddr, iwait}), 96'({1'b1, 32'h44, 1'b0}));
        step(); iREN = 1'b0; ramstate = FREE;
        @(negedge CLK);

        // Randomized traffic against the RAM model
        for (int k = 0; k < 3000; k++) begin
            step();
            if (i_pend && $urandom_range(0, 29) == 0) begin
                iREN = 1'b0; i_pend = 1'b0; void'(iq.pop_back());
            end else if (!i_pend) begin
                if ($urandom_range(0, 2) == 0) begin
                    iaddr = 32'h400 + (32'($urandom_range(0, 255)) << 2);
                    iREN = 1'b1; i_pend = 1'b1;
                    iq.push_back(ref_read(iaddr));
                end else begin
                    iREN = 1'b0;
                end
            end
            if (d_pend && $urandom_range(0, 29) == 0) begin
                dREN = 1'b0; dWEN = 1'b0; d_pend = 1'b0; void'(dq.pop_back());
            end else if (!d_pend) begin
                if ($urandom_range(0, 1) == 0) begin
                    daddr = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                    d_pend = 1'b1;
                    if ($urandom_range(0, 1) == 1) begin
                        dWEN = 1'b1; dREN = 1'($urandom_range(0, 1)); dstore = $urandom;
                        dq.push_back('{1'b1, daddr, dstore});
                    end else begin
                        dWEN = 1'b0; dREN = 1'b1;
                        dq.push_back('{1'b0, daddr, ref_read(daddr)});
                    end
                end else begin
                    dREN = 1'b0; dWEN = 1'b0;
                end
            end
            #1;
            if (ramREN | ramWEN) begin
                r = $urandom_range(0, 4);
                ramstate = (r < 2) ? ACCESS : ((r < 4) ? BUSY : ERROR);
            end else begin
                ramstate = FREE;
            end
            ramload = (ramstate == ACCESS && ramREN) ? ram_read(ramaddr) : $urandom;
            @(negedge CLK);
            if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr] = ramstore;
            if (!iwait) i_pend = 1'b0;
            if (!dwait) d_pend = 1'b0;
        end

        // Drain outstanding requests
        for (int k = 0; k < 200 && (i_pend || d_pend); k++) begin
            step();
            if (!i_pend) iREN = 1'b0;
            if (!d_pend) begin dREN = 1'b0; dWEN = 1'b0; end
            #1;
            ramstate = (ramREN | ramWEN) ? ACCESS : FREE;
            ramload = ram_read(ramaddr);
            @(negedge CLK);
            if (ramWEN && ramstate == ACCESS) ram_mem[ramaddr] = ramstore;
            if (!iwait) i_pend = 1'b0;
            if (!dwait) d_pend = 1'b0;
        end
        step(); iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        check("drain_done", 96'({i_pend, d_pend}), 96'(0));
        check("iq_empty", 96'(iq.size()), 96'(0));
        check("dq_empty", 96'(dq.size()), 96'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter between the instruction cache (I side) and data cache (D side) of the pipelined core. It serializes requests onto the shared RAM port and gives data accesses priority. A streak counter guarantees instruction fetch progress under sustained data traffic. It returns per-side wait/load signals to the caches, which the pipeline's stall and forwarding logic consume.

## Interface
- MAX_DSTREAK, default 4: maximum consecutive D grants while an I request is pending before I is forced.
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  32  instruction word address.
- iwait  out  1  low for exactly the cycle the I read completes.
- iload  out  32  instruction read data, valid when iwait low.
- dREN  in  1  data read request.
- dWEN  in  1  data write request (wins over dREN if both high).
- daddr  in  32  data address.
- dstore  in  32  data write value.
- dwait  out  1  low for exactly the cycle the D access completes.
- dload  out  32  data read data, valid when dwait low.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t from cpu_types_pkg: FREE, BUSY, ACCESS, ERROR.

## Operation
- States:
  - IDLE: no RAM request driven.
  - DSERV: RAM driven from the D side.
  - ISERV: RAM driven from the I side.
- IDLE transitions (registered):
  - Go to ISERV if iREN and dstreak == MAX_DSTREAK.
  - Else go to DSERV if dREN|dWEN.
  - Else go to ISERV if iREN.
  - Else stay in IDLE.
- DSERV outputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&~dWEN.
- ISERV outputs:
  - ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Outputs in IDLE: all ram* outputs 0.
- iload=ramload and dload=ramload unconditionally (combinational passthrough).
- Completion:
  - In DSERV with ramstate==ACCESS: dwait=0 that cycle; next state IDLE.
  - In ISERV with ramstate==ACCESS: iwait=0 that cycle; next state IDLE.
  - The mandatory IDLE cycle prevents re-granting a request that is still asserted on its completion cycle.
- BUSY and ERROR: hold state and outputs, keep the served side's wait high, and keep requesting. ERROR is retried identically to BUSY and is never reported to the caches.
- Request withdrawn mid-service (served side's REN/WEN low, or both D enables low in DSERV):
  - Next state IDLE.
  - No wait pulse.
  - dstreak unchanged.
- dstreak (3-bit saturating, 0..MAX_DSTREAK):
  - D completion with iREN high: increment, saturating at MAX_DSTREAK.
  - D completion with iREN low: clear to 0.
  - I completion: clear to 0.
- All outputs are combinational from state, requests and ramstate. Only the state and dstreak are registered.

## Timing
- Reset (nRST low, asynchronous):
  - State IDLE, dstreak 0.
  - iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Effective mid-transaction. The RAM request drops immediately and the in-flight access is abandoned with no completion pulse.
- Latency:
  - Request first seen in IDLE at edge n; RAM request driven in cycle n+1.
  - Minimum completion cycle is n+1, when RAM returns ACCESS in the first served cycle.
  - Back-to-back accesses are spaced by at least one IDLE cycle.
- Simultaneous I and D requests in IDLE:
  - D wins unless dstreak == MAX_DSTREAK.
  - After a forced I grant, dstreak is 0, so D wins the next tie.
- The served side's address and data must be held stable while its wait is high. This is a cache-side requirement and is not checked by the arbiter.
- A wait output is never low outside its own serve state.

## Test plan
- Reset then idle (no requests):
  - Required: all ram* outputs 0, iwait=dwait=1.
  - State IDLE for 10 cycles.
- Single I read (iREN, iaddr=0x40; RAM gives BUSY×2 then ACCESS with ramload=0x8C220004):
  - Required: ramREN=1, ramaddr=0x40 from cycle 1.
  - iwait=0 and iload=0x8C220004 in cycle 3 only.
- Tie (iREN and dWEN in the same cycle, daddr=0x100, dstore=0xDEAD; ACCESS after 1 BUSY):
  - Required: D served first with ramWEN=1, ramstore=0xDEAD.
  - Then one IDLE cycle, then I served.
- Starvation guard (MAX_DSTREAK=4; iREN held, 6 back-to-back D reads, each ACCESS-first):
  - Required: exactly 4 D completions, then an I grant, then the remaining D reads.
  - dstreak back to 0 after the I completion.
- ERROR then withdraw (D read gets ERROR×3 then ACCESS; second D read withdrawn in BUSY):
  - Required: the first read completes after the retries with dwait low once.
  - The withdrawn read produces no dwait pulse and the state returns to IDLE next cycle.
- nRST asserted during ISERV while BUSY:
  - Required: ramREN drops to 0 and iwait=1 without waiting for a clock edge.
  - After nRST release with iREN still high, I is re-granted from IDLE.
